unified_memory_ctrl: RTL

Parametrised unified instruction/data memory for the core, replacing the single-word, negedge-write memory. It has a registered instruction fetch port and a registered data port with byte/half/word access, sign/zero extension and per-request fault reporting. After reset, a sequential clear engine zeroes the array one word per cycle, and the block raises ready only when clearing is done.

---
 rtl/unified_memory_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/unified_memory_ctrl.sv
// Unified instruction/data memory: registered fetch port, registered byte/half/word
// data port with extension and fault reporting, and a post-reset sweep-clear engine.
module unified_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  ready,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_valid,
  output logic [31:0]           instr_rdata,
  output logic                  instr_fault,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic                  data_unsigned,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [31:0]           data_wdata,
  output logic                  data_valid,
  output logic [31:0]           data_rdata,
  output logic                  data_fault
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [0:0]  ST_CLEAR = 1'b0;
  localparam logic [0:0]  ST_READY = 1'b1;
  localparam logic [0:0]  ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             ready_q, ready_d;

  logic             instr_valid_q, instr_fault_q;
  logic [31:0]      instr_rdata_q;
  logic             data_valid_q, data_fault_q;
  logic [31:0]      data_rdata_q;

  // Clear sweep: one word per cycle, READY after the last index is written.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_READY;
    end
    ready_d = (state_d == ST_READY);
  end

  // Fetch port decode
  logic             instr_acc, instr_in_range;
  logic [IDX_W-1:0] instr_idx;
  assign instr_acc      = instr_req & ready_q;
  assign instr_idx      = instr_addr[IDX_W+1:2];
  assign instr_in_range = ~|instr_addr[ADDR_WIDTH-1:IDX_W+2];

  // Data port decode
  logic             data_acc, data_in_range, data_bad;
  logic [IDX_W-1:0] data_idx;
  logic [1:0]       data_off;
  logic [3:0]       data_be;
  logic [31:0]      wdata_rep, rd_word, rd_shift, load_ext;
  assign data_acc      = data_req & ready_q;
  assign data_idx      = data_addr[IDX_W+1:2];
  assign data_off      = data_addr[1:0];
  assign data_in_range = ~|data_addr[ADDR_WIDTH-1:IDX_W+2];
  assign rd_word       = mem_q[data_idx];
  assign rd_shift      = rd_word >> {data_off, 3'b000};

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    data_be   = 4'b0000;
    wdata_rep = data_wdata;
    load_ext  = rd_word;
    data_bad  = ~data_in_range;
    case (data_size)
      2'b00: begin
        data_be   = 4'b0001 << data_off;
        wdata_rep = {4{data_wdata[7:0]}};
        load_ext  = data_unsigned ? {24'b0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      end
      2'b01: begin
        data_be   = data_off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{data_wdata[15:0]}};
        load_ext  = data_unsigned ? {16'b0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
        data_bad  = data_bad | data_off[0];
      end
      2'b10: begin
        data_be  = 4'b1111;
        data_bad = data_bad | (data_off != 2'b00);
      end
      default: data_bad = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RESET;
      clr_cnt_q     <= '0;
      ready_q       <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_rdata_q <= '0;
      instr_fault_q <= 1'b0;
      data_valid_q  <= 1'b0;
      data_rdata_q  <= '0;
      data_fault_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      ready_q       <= ready_d;
      instr_valid_q <= instr_acc;
      instr_rdata_q <= (instr_acc && instr_in_range) ? mem_q[instr_idx] : '0;
      instr_fault_q <= instr_acc & ~instr_in_range;
      data_valid_q  <= data_acc;
      data_rdata_q  <= (data_acc && !data_we && !data_bad) ? load_ext : '0;
      data_fault_q  <= data_acc & data_bad;
    end
  end

  // NOTE: the array has no reset; it is zeroed by the clear sweep instead.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (data_acc && data_we && !data_bad) begin
      for (int b = 0; b < 4; b++)
        if (data_be[b]) mem_q[data_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
    end
  end

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^instr_addr[1:0];

  assign ready       = ready_q;
  assign instr_valid = instr_valid_q;
  assign instr_rdata = instr_rdata_q;
  assign instr_fault = instr_fault_q;
  assign data_valid  = data_valid_q;
  assign data_rdata  = data_rdata_q;
  assign data_fault  = data_fault_q;

endmodule
